// File: rtl/wormhole_output_allocator_pkg.sv
// Shared flit format and allocator state encoding for the wormhole output allocator.
// Flit layout: [15:14] flit type, [13:11] priority, [10:0] payload.
package wormhole_output_allocator_pkg;

  localparam int FLIT_SIZE  = 16;
  localparam int HEADER_LEN = 2;
  localparam int CMP_POS    = 13;
  localparam int CMP_LEN    = 3;

  localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b00;
  localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b01;
  localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10;
  localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/wormhole_output_allocator_rr_priority_picker.sv
// Combinational picker: highest priority among eligible inputs, ties broken by the
// first eligible index at or after rr_ptr (wrapping).
module wormhole_output_allocator_rr_priority_picker
  import wormhole_output_allocator_pkg::*;
#(
  parameter int N  = 6,
  parameter int W  = CMP_LEN,
  parameter int IW = $clog2(N)
) (
  input  logic [N*W-1:0] prio,
  input  logic [N-1:0]   elig,
  input  logic [IW-1:0]  rr_ptr,
  output logic [N-1:0]   grant,
  output logic [IW-1:0]  grant_idx,
  output logic           grant_valid
);

  logic [W-1:0]  max_prio_s;
  logic [N-1:0]  cand_s;
  logic          hi_found_s;
  logic [IW-1:0] hi_idx_s;
  logic          lo_found_s;
  logic [IW-1:0] lo_idx_s;

  // Max priority, tied candidates, then round-robin pick among the candidates
  always_comb begin
    max_prio_s = '0;
    cand_s     = '0;
    hi_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_found_s = 1'b0;
    lo_idx_s   = '0;
    grant      = '0;
    for (int i = 0; i < N; i++) begin
      if (elig[i] && (prio[i*W +: W] > max_prio_s)) begin
        max_prio_s = prio[i*W +: W];
      end else begin
        max_prio_s = max_prio_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      cand_s[i] = elig[i] && (prio[i*W +: W] == max_prio_s);
    end
    // Descending scan: the last hit is the lowest index (overall and at/after rr_ptr)
    for (int i = N - 1; i >= 0; i--) begin
      if (cand_s[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = IW'(i);
        if (IW'(i) >= rr_ptr) begin
          hi_found_s = 1'b1;
          hi_idx_s   = IW'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    grant_valid = lo_found_s;
    grant_idx   = hi_found_s ? hi_idx_s : lo_idx_s;
    for (int i = 0; i < N; i++) begin
      grant[i] = grant_valid && (grant_idx == IW'(i));
    end
  end

endmodule

// File: rtl/wormhole_output_allocator.sv
// Credit-gated, packet-locking N-to-1 output allocator with a registered output flit.
// Optional starvation aging is enabled by defining WORMHOLE_ALLOC_AGING_EN.
module wormhole_output_allocator
  import wormhole_output_allocator_pkg::*;
#(
  parameter int N         = 6,
  parameter int CREDITS   = 4,
  parameter int AGE_LIMIT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FLIT_SIZE*N-1:0] in_flit,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  input  logic                   credit_return,
  output logic [FLIT_SIZE-1:0]   out_flit,
  output logic                   out_valid,
  output logic                   lock_active,
  output logic [$clog2(N)-1:0]   grant_id
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(CREDITS + 1);

  alloc_state_t                   state_r, state_nx_s;
  logic [IW-1:0]                  owner_r, owner_nx_s;
  logic [IW-1:0]                  rr_ptr_r, rr_ptr_nx_s;
  logic [IW-1:0]                  grant_id_r, grant_id_nx_s;
  logic [IW-1:0]                  sel_idx_s;
  logic [CW-1:0]                  credit_cnt_r, credit_nx_s;
  logic [FLIT_SIZE-1:0]           out_flit_r, sel_flit_s;
  logic                           out_valid_r, lock_active_r;
  logic                           send_s, credit_ok_s;
  logic [N-1:0]                   in_ready_s;
  logic [N-1:0][HEADER_LEN-1:0]   ftype_s;
  logic [N-1:0][CMP_LEN-1:0]      prio_s;
  logic [N-1:0]                   elig_s;
  logic [N-1:0]                   aged_s;
  logic [N*CMP_LEN-1:0]           eff_prio_s;
  logic [N-1:0]                   pick_grant_s;
  logic [IW-1:0]                  pick_idx_s;
  logic                           pick_valid_s;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
    if (idx == IW'(N - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = idx + IW'(1);
    end
  endfunction

  assign credit_ok_s = (credit_cnt_r != '0);

  // Per-input field decode and head-flit eligibility
  always_comb begin
    ftype_s    = '0;
    prio_s     = '0;
    elig_s     = '0;
    eff_prio_s = '0;
    for (int i = 0; i < N; i++) begin
      ftype_s[i] = in_flit[FLIT_SIZE*i + FLIT_SIZE - 1 -: HEADER_LEN];
      prio_s[i]  = in_flit[FLIT_SIZE*i + CMP_POS -: CMP_LEN];
      elig_s[i]  = in_valid[i] && credit_ok_s &&
                   ((ftype_s[i] == HEAD_FLIT) || (ftype_s[i] == SINGLE_FLIT));
      eff_prio_s[i*CMP_LEN +: CMP_LEN] = aged_s[i] ? {CMP_LEN{1'b1}} : prio_s[i];
    end
  end

`ifdef WORMHOLE_ALLOC_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [N-1:0][AW-1:0] age_r;

  // Starved inputs compete at the top priority level
  always_comb begin
    aged_s = '0;
    for (int i = 0; i < N; i++) begin
      aged_s[i] = (age_r[i] >= AW'(AGE_LIMIT));
    end
  end

  // Age counts lost IDLE arbitrations; cleared on grant or when the input drops
  always_ff @(posedge clk) begin
    if (rst) begin
      age_r <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i]) begin
          age_r[i] <= '0;
        end else if ((state_r == IDLE) && pick_grant_s[i]) begin
          age_r[i] <= '0;
        end else if ((state_r == IDLE) && elig_s[i] && (age_r[i] < AW'(AGE_LIMIT))) begin
          age_r[i] <= age_r[i] + AW'(1);
        end else begin
          age_r[i] <= age_r[i];
        end
      end
    end
  end
`else
  assign aged_s = '0;
`endif

  wormhole_output_allocator_rr_priority_picker #(
    .N  (N),
    .W  (CMP_LEN),
    .IW (IW)
  ) u_picker (
    .prio        (eff_prio_s),
    .elig        (elig_s),
    .rr_ptr      (rr_ptr_r),
    .grant       (pick_grant_s),
    .grant_idx   (pick_idx_s),
    .grant_valid (pick_valid_s)
  );

  // FSM next state, handshake and transfer select
  always_comb begin
    state_nx_s    = state_r;
    owner_nx_s    = owner_r;
    rr_ptr_nx_s   = rr_ptr_r;
    grant_id_nx_s = grant_id_r;
    sel_idx_s     = owner_r;
    in_ready_s    = '0;
    send_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          in_ready_s    = pick_grant_s;
          send_s        = 1'b1;
          sel_idx_s     = pick_idx_s;
          grant_id_nx_s = pick_idx_s;
          rr_ptr_nx_s   = rr_next(pick_idx_s);
          if (ftype_s[pick_idx_s] == HEAD_FLIT) begin
            state_nx_s = LOCKED;
            owner_nx_s = pick_idx_s;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      LOCKED: begin
        in_ready_s[owner_r] = credit_ok_s;
        if (credit_ok_s && in_valid[owner_r]) begin
          send_s = 1'b1;
          if (ftype_s[owner_r] == TAIL_FLIT) begin
            state_nx_s  = IDLE;
            rr_ptr_nx_s = rr_next(owner_r);
          end else begin
            state_nx_s = LOCKED;
          end
        end else begin
          state_nx_s = LOCKED;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Flit mux for the transferring input
  always_comb begin
    sel_flit_s = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_idx_s == IW'(i)) begin
        sel_flit_s = in_flit[FLIT_SIZE*i +: FLIT_SIZE];
      end else begin
        sel_flit_s = sel_flit_s;
      end
    end
  end

  // Credit update; a return at full credit is dropped
  always_comb begin
    case ({send_s, credit_return})
      2'b10:   credit_nx_s = credit_cnt_r - CW'(1);
      2'b01:   credit_nx_s = (credit_cnt_r == CW'(CREDITS)) ? credit_cnt_r : credit_cnt_r + CW'(1);
      default: credit_nx_s = credit_cnt_r;
    endcase
  end

  // State and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      owner_r       <= '0;
      rr_ptr_r      <= '0;
      grant_id_r    <= '0;
      credit_cnt_r  <= CW'(CREDITS);
      out_flit_r    <= '0;
      out_valid_r   <= 1'b0;
      lock_active_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      owner_r       <= owner_nx_s;
      rr_ptr_r      <= rr_ptr_nx_s;
      grant_id_r    <= grant_id_nx_s;
      credit_cnt_r  <= credit_nx_s;
      out_valid_r   <= send_s;
      lock_active_r <= (state_nx_s == LOCKED);
      if (send_s) begin
        out_flit_r <= sel_flit_s;
      end else begin
        out_flit_r <= out_flit_r;
      end
    end
  end

  assign in_ready    = in_ready_s;
  assign out_flit    = out_flit_r;
  assign out_valid   = out_valid_r;
  assign lock_active = lock_active_r;
  assign grant_id    = grant_id_r;

endmodule
